// File: rtl/aes_pkcs7_padder.sv
// aes_pkcs7_padder: appends PKCS#7 padding to a 32-bit plaintext stream so it fills whole 16-byte AES blocks.
module aes_pkcs7_padder #(
   parameter int LEN_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_data_o,
   output logic [3:0]       out_strb_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [LEN_W-1:0] word_cnt_o
);
   typedef enum logic [1:0] {IDLE, PASS, PAD, DRAIN} state_e;
   state_e state_q, state_d;
   logic [4:0]       pad_q;
   logic [1:0]       rem_q;
   logic [LEN_W-1:0] in_words_q, total_q, loaded_q, st_in_words, st_total;
   logic             load_ok, in_hs, out_hs, pad_ld, last_in;
   logic [7:0]       pad_byte;
   logic [31:0]      pass_data, ld_data;

   assign st_in_words = (len_i >> 2) + LEN_W'(|len_i[1:0]);
   assign st_total    = ((len_i >> 4) + LEN_W'(1)) << 2;
   assign load_ok     = enable_i & (~out_valid_o | out_ready_i);
   assign in_ready_o  = (state_q == PASS) & load_ok;
   assign in_hs       = in_valid_i & in_ready_o;
   assign out_hs      = out_valid_o & out_ready_i;
   assign pad_ld      = (state_q == PAD) & load_ok;
   // In PASS every loaded word is an input word, so loaded_q doubles as the input counter
   assign last_in     = loaded_q == in_words_q - LEN_W'(1);
   assign pad_byte    = {3'b000, pad_q};
   assign ld_data     = (state_q == PASS) ? pass_data : {4{pad_byte}};
   assign busy_o      = state_q != IDLE;
   assign done_o      = (state_q == DRAIN) & out_hs & ~clear_i;
   assign out_strb_o  = 4'hF;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign pass_data[8*k +: 8] = (last_in && rem_q != 2'd0 && 2'(k) >= rem_q) ? pad_byte : in_data_i[8*k +: 8];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start_i) state_d = (st_in_words != '0) ? PASS : PAD;
         PASS:  if (in_hs && last_in) state_d = (loaded_q + LEN_W'(1) < total_q) ? PAD : DRAIN;
         PAD:   if (pad_ld && loaded_q + LEN_W'(1) == total_q) state_d = DRAIN;
         DRAIN: if (out_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clear_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pad_q       <= '0;
         rem_q       <= '0;
         in_words_q  <= '0;
         total_q     <= '0;
         loaded_q    <= '0;
         word_cnt_o  <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else if (clear_i) begin
         pad_q       <= '0;
         rem_q       <= '0;
         in_words_q  <= '0;
         total_q     <= '0;
         loaded_q    <= '0;
         word_cnt_o  <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else begin
         if (state_q == IDLE && start_i) begin
            pad_q      <= 5'd16 - {1'b0, len_i[3:0]};
            rem_q      <= len_i[1:0];
            in_words_q <= st_in_words;
            total_q    <= st_total;
            loaded_q   <= '0;
            word_cnt_o <= '0;
         end
         if (in_hs || pad_ld) begin
            out_data_o  <= ld_data;
            out_valid_o <= 1'b1;
            loaded_q    <= loaded_q + LEN_W'(1);
         end else if (out_hs) begin
            out_valid_o <= 1'b0;
         end
         if (out_hs) word_cnt_o <= word_cnt_o + LEN_W'(1);
         if (state_q == DRAIN && out_hs) loaded_q <= '0;
      end
   end
endmodule

// File: tb/tb_aes_pkcs7_padder.sv
// tb_aes_pkcs7_padder: directed tests of the PKCS#7 padder with hand-computed expected streams.
module tb_aes_pkcs7_padder;
   logic        clk_i = 0, rst_ni = 0, clear_i = 0, enable_i = 1, start_i = 0;
   logic [31:0] len_i = 0, in_data_i = 0, out_data_o, word_cnt_o;
   logic        in_valid_i = 0, in_ready_o, out_valid_o, out_ready_i = 1, busy_o, done_o;
   logic [3:0]  out_strb_o;
   logic [31:0] din[16];
   logic [31:0] exp_w[8];
   logic [31:0] got[$];
   int          total = 0, bad = 0;
   int          done_idx, done_bad, stall_viol, en_viol, ir_seen, timed_out;

   aes_pkcs7_padder #(.LEN_W(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i), .start_i(start_i),
      .len_i(len_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_strb_o(out_strb_o), .busy_o(busy_o), .done_o(done_o), .word_cnt_o(word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic run(input logic [31:0] len, input int nin, input bit rnd, input int en_off, input int clr_at);
      int idx = 0;
      bit fin = 0, prev_stall = 0, prev_en = 1;
      logic [31:0] prev_data = 0;
      got.delete();
      done_idx = -1; done_bad = 0; stall_viol = 0; en_viol = 0; ir_seen = 0; timed_out = 1;
      @(negedge clk_i); start_i = 1; len_i = len;
      @(negedge clk_i); start_i = 0;
      for (int c = 0; c < 400; c++) begin
         enable_i    = !(en_off >= 0 && c >= en_off && c < en_off + 5);
         out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid_i  = idx < nin;
         in_data_i   = idx < nin ? din[idx] : 32'h0;
         clear_i     = c == clr_at;
         #1;
         if (in_ready_o) ir_seen = 1;
         if (prev_stall && (!out_valid_o || out_data_o !== prev_data)) stall_viol++;
         if (out_valid_o && !prev_stall && !prev_en) en_viol++;
         if (!enable_i && in_ready_o) en_viol++;
         if (out_valid_o && out_ready_i && !clear_i) begin
            got.push_back(out_data_o);
            if (done_o) begin done_idx = got.size(); fin = 1; end
         end else if (done_o) done_bad++;
         if (in_valid_i && in_ready_o && !clear_i) idx++;
         prev_stall = out_valid_o && !out_ready_i;
         prev_data  = out_data_o;
         prev_en    = enable_i;
         @(negedge clk_i);
         if (fin || clear_i) begin timed_out = 0; break; end
      end
      clear_i = 0; in_valid_i = 0; out_ready_i = 1; enable_i = 1;
      #1;
   endtask

   task automatic test_reset;
      rst_ni = 0;
      repeat (2) @(negedge clk_i);
      total++; if ({out_valid_o, in_ready_o, busy_o, done_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b need=0000", {out_valid_o, in_ready_o, busy_o, done_o}); end
      total++; if (out_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h need=00000000", out_data_o); end
      total++; if (word_cnt_o !== 32'h0) begin bad++; $display("FAIL reset_wcnt got=%0d need=0", word_cnt_o); end
      total++; if (out_strb_o !== 4'hF) begin bad++; $display("FAIL strb got=%h need=f", out_strb_o); end
      rst_ni = 1;
      @(negedge clk_i); start_i = 1; len_i = 20; out_ready_i = 0; in_valid_i = 1; in_data_i = 32'h55;
      @(negedge clk_i); start_i = 0;
      @(negedge clk_i);
      total++; if ({out_valid_o, busy_o} !== 2'b11) begin bad++; $display("FAIL pre_async got=%b need=11", {out_valid_o, busy_o}); end
      #2 rst_ni = 0;
      #1;
      total++; if ({out_valid_o, busy_o} !== 2'b00) begin bad++; $display("FAIL async_reset got=%b need=00", {out_valid_o, busy_o}); end
      in_valid_i = 0; out_ready_i = 1;
      @(negedge clk_i); rst_ni = 1;
   endtask

   task automatic test_len20;
      for (int i = 0; i < 5; i++) din[i] = 32'h1000_0000 + i;
      for (int i = 0; i < 8; i++) exp_w[i] = i < 5 ? din[i] : 32'h0C0C0C0C;
      run(20, 5, 0, -1, -1);
      total++; if (timed_out != 0 || got.size() != 8) begin bad++; $display("FAIL len20_count got=%0d need=8 timeout=%0d", got.size(), timed_out); end
      for (int i = 0; i < 8; i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL len20_w%0d got=%h need=%h", i, got[i], exp_w[i]); end
      end
      total++; if (done_idx != 8 || done_bad != 0) begin bad++; $display("FAIL len20_done got=%0d/%0d need=8/0", done_idx, done_bad); end
      total++; if (word_cnt_o !== 32'd8) begin bad++; $display("FAIL len20_wcnt got=%0d need=8", word_cnt_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL len20_idle got=%b need=0", busy_o); end
   endtask

   task automatic test_len17;
      for (int i = 0; i < 4; i++) din[i] = 32'h2000_0000 + i;
      din[4] = 32'hAABBCCDD;
      for (int i = 0; i < 8; i++) exp_w[i] = i < 4 ? din[i] : (i == 4 ? 32'h0F0F0FDD : 32'h0F0F0F0F);
      run(17, 5, 0, -1, -1);
      total++; if (timed_out != 0 || got.size() != 8) begin bad++; $display("FAIL len17_count got=%0d need=8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL len17_w%0d got=%h need=%h", i, got[i], exp_w[i]); end
      end
   endtask

   task automatic test_len13;
      for (int i = 0; i < 3; i++) din[i] = 32'h3000_0000 + i;
      din[3] = 32'hDEADBEEF;
      run(13, 4, 0, -1, -1);
      total++; if (timed_out != 0 || got.size() != 4 || done_idx != 4) begin bad++; $display("FAIL len13_count got=%0d done=%0d need=4", got.size(), done_idx); end
      total++; if (got[3] !== 32'h030303EF) begin bad++; $display("FAIL len13_last got=%h need=030303ef", got[3]); end
      total++; if (got[0] !== din[0]) begin bad++; $display("FAIL len13_w0 got=%h need=%h", got[0], din[0]); end
   endtask

   task automatic test_len16;
      for (int i = 0; i < 4; i++) din[i] = 32'h4000_0000 + i;
      for (int i = 0; i < 8; i++) exp_w[i] = i < 4 ? din[i] : 32'h10101010;
      run(16, 4, 0, -1, -1);
      total++; if (timed_out != 0 || got.size() != 8) begin bad++; $display("FAIL len16_count got=%0d need=8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL len16_w%0d got=%h need=%h", i, got[i], exp_w[i]); end
      end
   endtask

   task automatic test_len0;
      run(0, 0, 0, -1, -1);
      total++; if (timed_out != 0 || got.size() != 4 || done_idx != 4) begin bad++; $display("FAIL len0_count got=%0d done=%0d need=4", got.size(), done_idx); end
      for (int i = 0; i < 4; i++) begin
         total++; if (got[i] !== 32'h10101010) begin bad++; $display("FAIL len0_w%0d got=%h need=10101010", i, got[i]); end
      end
      total++; if (ir_seen != 0) begin bad++; $display("FAIL len0_in_ready got=%0d need=0", ir_seen); end
   endtask

   task automatic test_backpressure;
      din[0] = 32'hCAFEF00D; din[1] = 32'h01234567;
      exp_w[0] = din[0]; exp_w[1] = din[1]; exp_w[2] = 32'h08080808; exp_w[3] = 32'h08080808;
      run(8, 2, 1, -1, -1);
      total++; if (timed_out != 0 || got.size() != 4 || done_idx != 4) begin bad++; $display("FAIL bp_count got=%0d done=%0d need=4", got.size(), done_idx); end
      for (int i = 0; i < 4; i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL bp_w%0d got=%h need=%h", i, got[i], exp_w[i]); end
      end
      total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d need=0", stall_viol); end
   endtask

   task automatic test_enable;
      for (int i = 0; i < 5; i++) din[i] = 32'h5000_0000 + 32'h0101 * i;
      for (int i = 0; i < 8; i++) exp_w[i] = i < 5 ? din[i] : 32'h0C0C0C0C;
      run(20, 5, 0, 2, -1);
      total++; if (en_viol != 0) begin bad++; $display("FAIL en_hold got=%0d need=0", en_viol); end
      total++; if (timed_out != 0 || got.size() != 8) begin bad++; $display("FAIL en_count got=%0d need=8", got.size()); end
      for (int i = 0; i < 8; i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL en_w%0d got=%h need=%h", i, got[i], exp_w[i]); end
      end
   endtask

   task automatic test_clear;
      for (int i = 0; i < 5; i++) din[i] = 32'h6000_0000 + i;
      run(20, 5, 0, -1, 6);
      total++; if ({out_valid_o, busy_o} !== 2'b00) begin bad++; $display("FAIL clr_state got=%b need=00", {out_valid_o, busy_o}); end
      total++; if (done_idx != -1 || done_bad != 0 || done_o !== 1'b0) begin bad++; $display("FAIL clr_done got=%0d/%0d need=-1/0", done_idx, done_bad); end
      total++; if (word_cnt_o !== 32'd0) begin bad++; $display("FAIL clr_wcnt got=%0d need=0", word_cnt_o); end
      din[0] = 32'h12345678;
      exp_w[0] = din[0]; exp_w[1] = 32'h0C0C0C0C; exp_w[2] = 32'h0C0C0C0C; exp_w[3] = 32'h0C0C0C0C;
      run(4, 1, 0, -1, -1);
      total++; if (timed_out != 0 || got.size() != 4 || done_idx != 4) begin bad++; $display("FAIL clr_next_count got=%0d need=4", got.size()); end
      for (int i = 0; i < 4; i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL clr_next_w%0d got=%h need=%h", i, got[i], exp_w[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_len20;
      test_len17;
      test_len13;
      test_len16;
      test_len0;
      test_backpressure;
      test_enable;
      test_clear;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_pkcs7_padder.md
Name: aes_pkcs7_padder

Overview:
Upstream stage of the AES-CBC engine. It takes the raw 32-bit plaintext stream of a message of len_i bytes and appends PKCS#7 padding so the output is a whole number of 16-byte AES blocks. Its output stream feeds the engine's plaintext (a) input directly. The engine's stacker groups every 4 words into one 128-bit block.

Parameters:
LEN_W, 32, width of the message byte-length input and of internal byte/word counters.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear; aborts the current message
enable_i  in  1  global enable; when low, no new word is loaded and the FSM holds
start_i  in  1  one-cycle start pulse; samples len_i
len_i  in  LEN_W  message length in bytes; 0 is legal
in_valid_i  in  1  plaintext stream valid
in_ready_o  out  1  plaintext stream ready
in_data_i  in  32  plaintext word; byte k is data[8k+7:8k]; byte 0 is first in the message
out_valid_o  out  1  padded stream valid
out_ready_i  in  1  padded stream ready
out_data_o  out  32  padded word
out_strb_o  out  4  always 4'hF
busy_o  out  1  high when the FSM is not IDLE
done_o  out  1  one-cycle pulse on the final output handshake
word_cnt_o  out  LEN_W  number of output words accepted downstream in the current message

Behaviour:
- Reset (rst_ni low, async): FSM=IDLE; out_valid_o=0; out_data_o=0; in_ready_o=0; busy_o=0; done_o=0; word_cnt_o=0.
- Clear (clear_i high): same values as reset, applied synchronously. Clear has priority over start_i and over any handshake in the same cycle.
- Start-time values, computed at start_i in IDLE:
  - p = 16 - len_i[3:0], range 1..16.
  - in_words = ceil(len_i/4).
  - total_words = 4*(floor(len_i/16)+1).
  - All values are registered. start_i outside IDLE is ignored.
- Output stage: a single register. A load is allowed when enable_i=1 and (out_valid_o=0 or out_ready_i=1). Latency is 1 cycle from input handshake to out_valid_o.
- The output handshake drains the register even while enable_i=0. out_valid_o never drops without a handshake, except on clear or reset.
- in_ready_o = (state==PASS) & enable_i & load-allowed. It is purely combinational from the register state and out_ready_i.
- FSM states and transitions:
  - IDLE: on start_i, go to PASS if in_words>0, else go to PAD.
  - PASS: each input handshake loads in_data_i and increments in_cnt.
    - On the last input word (in_cnt==in_words-1), if r=len[1:0]!=0, byte lanes k>=r are replaced by p. Lanes k<r pass unchanged.
    - After the last word: go to PAD if loaded_cnt+1 < total_words, else go to DRAIN.
  - PAD: each allowed load writes {4{p[7:0]}}, where p=16 is written as 8'h10. Go to DRAIN when loaded_cnt reaches total_words.
  - DRAIN: on the output handshake, pulse done_o, go to IDLE, and clear the counters except word_cnt_o. word_cnt_o holds its final value until the next start_i.
- Counters: loaded_cnt counts words written to the output register; word_cnt_o counts output handshakes. Both are compared and incremented modulo 2^LEN_W, with no saturation. len_i must be < 2^LEN_W-16, which is a documented precondition.
- Simultaneous output drain and load in the same cycle: the register updates with no bubble, giving full throughput of 1 word/cycle.
- in_valid_i while in IDLE/PAD/DRAIN: ignored, and in_ready_o=0.
- Input words beyond in_words are never accepted.

Test Plan:
- len=20, 5 input words, out_ready_i=1: 8 output words; words 0-4 equal the input, words 5-7 = 0x0C0C0C0C; done_o pulses on the 8th handshake; word_cnt_o=8.
- len=17, last input word 0xAABBCCDD: output word 4 = 0x0F0F0FDD; words 5-7 = 0x0F0F0F0F; 8 words in total.
- len=16 and len=0: len=16 gives 4 pass-through words then 4 words of 0x10101010; len=0 gives exactly 4 words of 0x10101010 and never raises in_ready_o.
- Backpressure: len=8, out_ready_i toggling randomly: out_data_o/out_valid_o are stable while stalled, there are no lost or duplicate words, and the output is 2 data words plus 2 words of 0x08080808.
- enable_i low for 5 cycles mid-PASS: the held word drains, no new load occurs, and the stream resumes unchanged after enable returns.
- clear_i asserted mid-PAD: the next cycle shows out_valid_o=0, busy_o=0, no done_o pulse; a following start with len=4 yields 0xXXXXXXXX,0x0C0C0C0C x3.
